// File: rtl/rr_packet_arbiter_pkg.sv
// Shared definitions for the round-robin packet arbiter.
//   - arb_state_e : two-state arbitration FSM encoding
//   - idx_w       : width of a binary requester index, never below 1
//   - cnt_w       : width of the watchdog hold counter for a given limit
//   - rot_idx     : rotating index arithmetic, (base + off) mod n
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic int cnt_w(input int max_hold);
    if (max_hold < 1) begin
      return 1;
    end else begin
      return $clog2(max_hold + 1);
    end
  endfunction

  function automatic int rot_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between the input port buffers, the arbiter and the
// downstream crossbar port.
//   req_valid/req_last/req_data : per-requester flit stream (requester i at
//                                 req_data[i*DATA_W +: DATA_W])
//   req_ready                   : per-requester accept
//   out_valid/out_last/out_data : muxed winner stream, out_ready accepts it
//   grant/grant_idx/grant_vld   : registered one-hot grant, binary index, valid
//   stall_err                   : one-cycle pulse on watchdog release
// Modport slave is the arbiter side, master is the environment side.
interface rr_packet_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
) ();
  import arb_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic                    out_last;
  logic [DATA_W-1:0]       out_data;
  logic                    out_ready;
  logic [N_REQ-1:0]        grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_vld;
  logic                    stall_err;

  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_last, out_data,
    output grant, grant_idx, grant_vld, stall_err
  );

  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_last, out_data,
    input  grant, grant_idx, grant_vld, stall_err
  );

endinterface

// File: rtl/rr_packet_arbiter_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector
//   ptr    : index holding highest priority
//   found  : some request is set
//   idx    : first set request searching ptr, ptr+1, ..., wrapping
//   onehot : one-hot form of idx, zero when nothing found
// Doubling the vector and shifting by ptr puts requester (ptr+k) mod N at
// bit k, so a plain lowest-set-bit search yields the round-robin winner.
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [2*N_REQ-1:0] dbl_s;
  logic [N_REQ-1:0]   rot_s;
  int                 off_s;

  // rotate, find first set bit, map the offset back to an absolute index
  always_comb begin
    dbl_s  = {req, req} >> ptr;
    rot_s  = dbl_s[N_REQ-1:0];
    found  = 1'b0;
    off_s  = 0;
    onehot = '0;
    // descending scan so the lowest set offset is the last one written
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = k;
      end else begin
        off_s = off_s;
      end
    end
    idx = IDX_W'(rot_idx(int'(ptr), off_s, N_REQ));
    if (found) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin arbiter with packet locking and a stall watchdog.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : rr_packet_arbiter_if.slave (requester streams in, muxed stream and
//         grant status out)
// A grant is taken from IDLE one cycle after a request and is held until the
// owner's last flit transfers or the watchdog expires; in either case the
// next winner is loaded on the same edge so packets run back to back.
module rr_packet_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 255
) (
  input  logic                clk,
  input  logic                rst,
  rr_packet_arbiter_if.slave  bus
);

  localparam int IDX_W  = idx_w(N_REQ);
  localparam int HOLD_W = cnt_w(MAX_HOLD);
  localparam logic             WD_EN     = (MAX_HOLD > 0) ? 1'b1 : 1'b0;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  arb_state_e         state_r, state_s;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic               grant_vld_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic               stall_err_r;

  logic               pick_found_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [N_REQ-1:0]   pick_onehot_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               xfer_s;
  logic               wd_fire_s;
  logic               release_s;
  logic               load_s;

  // ptr already points past the current owner, so the owner ranks last when
  // re-arbitrating on release
  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_r),
    .found  (pick_found_s),
    .idx    (pick_idx_s),
    .onehot (pick_onehot_s)
  );

  // winner mux; everything reads zero while no grant is held
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    if (grant_vld_r) begin
      sel_valid_s = bus.req_valid[grant_idx_r];
      sel_last_s  = bus.req_last[grant_idx_r];
      sel_data_s  = bus.req_data[int'(grant_idx_r)*DATA_W +: DATA_W];
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  assign bus.out_valid = sel_valid_s;
  assign bus.out_last  = sel_last_s;
  assign bus.out_data  = sel_data_s;
  assign bus.req_ready = grant_r & {N_REQ{bus.out_ready}};
  assign bus.grant     = grant_r;
  assign bus.grant_idx = grant_idx_r;
  assign bus.grant_vld = grant_vld_r;
  assign bus.stall_err = stall_err_r;

  // next-state and release/load decisions
  always_comb begin
    xfer_s    = sel_valid_s & bus.out_ready;
    wd_fire_s = 1'b0;
    release_s = 1'b0;
    load_s    = 1'b0;
    state_s   = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          load_s  = 1'b1;
          state_s = ARB_LOCK;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_LOCK: begin
        if (WD_EN && !xfer_s && (hold_cnt_r == HOLD_LAST)) begin
          wd_fire_s = 1'b1;
        end else begin
          wd_fire_s = 1'b0;
        end
        release_s = (xfer_s & sel_last_s) | wd_fire_s;
        if (release_s) begin
          load_s  = pick_found_s;
          state_s = pick_found_s ? ARB_LOCK : ARB_IDLE;
        end else begin
          state_s = ARB_LOCK;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // grant registers and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r     <= '0;
      grant_idx_r <= '0;
      grant_vld_r <= 1'b0;
      ptr_r       <= '0;
    end else if (load_s) begin
      grant_r     <= pick_onehot_s;
      grant_idx_r <= pick_idx_s;
      grant_vld_r <= 1'b1;
      ptr_r       <= IDX_W'(rot_idx(int'(pick_idx_s), 1, N_REQ));
    end else if (release_s) begin
      grant_r     <= '0;
      grant_idx_r <= '0;
      grant_vld_r <= 1'b0;
    end
  end

  // stall counter: counts idle cycles under a grant, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_r <= '0;
    end else if (load_s || release_s || xfer_s) begin
      hold_cnt_r <= '0;
    end else if ((state_r == ARB_LOCK) && (hold_cnt_r != HOLD_SAT)) begin
      hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  end

  // watchdog release pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_err_r <= 1'b0;
    end else begin
      stall_err_r <= wd_fire_s;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Randomised and directed bench for rr_packet_arbiter (N_REQ=4, MAX_HOLD=8).
// A reference model tracks owner/pointer/stall count from the arbitration
// rules; every predicted flit transfer is queued and a separate monitor pops
// and compares whenever the DUT completes a transfer.
module tb_rr_packet_arbiter;
  import arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_packet_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  rr_packet_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q[$];
  logic [DW:0]   mon_e;
  logic [DW-1:0] flit [N];
  int owner, ptr, hold;
  bit wd_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // round-robin rule: first valid requester searching from p, wrapping
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_vec(input int pct);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ($urandom_range(99) < pct);
    return r;
  endfunction

  task automatic model_reset();
    owner = -1; ptr = 0; hold = 0; wd_prev = 0;
  endtask

  // one clock cycle: drive, check against the model, advance the model
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy, input bit new_data);
    logic [N-1:0] eg;
    bit ov, xfer, rel, wd;
    int p;
    if (new_data) begin
      for (int i = 0; i < N; i++) flit[i] = {$urandom, $urandom};
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.out_ready = rdy;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = flit[i];
    #2;
    eg = '0;
    if (owner >= 0) eg[owner] = 1'b1;
    ov = (owner >= 0) && v[owner];
    chk("grant",     64'(bus.grant),     64'(eg));
    chk("grant_vld", 64'(bus.grant_vld), 64'(owner >= 0));
    chk("grant_idx", 64'(bus.grant_idx), 64'((owner >= 0) ? owner : 0));
    chk("out_valid", 64'(bus.out_valid), 64'(ov));
    chk("out_data",  bus.out_data,       (owner >= 0) ? flit[owner] : 64'h0);
    chk("out_last",  64'(bus.out_last),  64'((owner >= 0) ? l[owner] : 1'b0));
    chk("req_ready", 64'(bus.req_ready), 64'(eg & {N{rdy}}));
    chk("stall_err", 64'(bus.stall_err), 64'(wd_prev));
    xfer = ov && rdy;
    if (xfer) exp_q.push_back({l[owner], flit[owner]});
    wd = 0;
    if (owner < 0) begin
      p = pick(v, ptr);
      if (p >= 0) begin owner = p; ptr = (p + 1) % N; hold = 0; end
    end else begin
      rel = xfer && l[owner];
      if (xfer) hold = 0;
      else if (hold == MH - 1) begin rel = 1; wd = 1; end
      else hold++;
      if (rel) begin
        p = pick(v, ptr);
        hold = 0;
        if (p >= 0) begin owner = p; ptr = (p + 1) % N; end
        else owner = -1;
      end
    end
    wd_prev = wd;
    @(posedge clk);
    #1;
  endtask

  // asynchronous reset asserted mid-cycle; outputs must drop immediately
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant",     64'(bus.grant),     64'h0);
    chk("rst_grant_vld", 64'(bus.grant_vld), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // scoreboard monitor: every DUT transfer must match the next predicted one
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got data %0h expected no transfer at %0t", bus.out_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_data", bus.out_data, mon_e[DW-1:0]);
        chk("xfer_last", 64'(bus.out_last), 64'(mon_e[DW]));
      end
    end
  end

  int pv[3] = '{70, 30, 90};
  int pl[3] = '{40, 20, 60};
  int pr[3] = '{80, 60, 30};

  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) flit[i] = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_grant",     64'(bus.grant),     64'h0);
    chk("reset_grant_idx", 64'(bus.grant_idx), 64'h0);
    chk("reset_grant_vld", 64'(bus.grant_vld), 64'h0);
    chk("reset_stall_err", 64'(bus.stall_err), 64'h0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fairness: all requesting single-flit packets, grants 0,1,2,3,0
    repeat (6) cycle(4'hF, 4'hF, 1'b1, 1'b1);

    // reset mid-run, then a lone request from requester 2
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
    chk("t1_grant",     64'(bus.grant),     64'h4);
    chk("t1_grant_idx", 64'(bus.grant_idx), 64'h2);

    // packet lock: req0 three flits, req1 joins on flit 2
    do_reset();
    cycle(4'b0001, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0001, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0011, 4'b0000, 1'b1, 1'b1);
    cycle(4'b0011, 4'b0001, 1'b1, 1'b1);
    chk("t3_grant", 64'(bus.grant), 64'h2);
    // backpressure mid-packet: data held stable, nothing moves
    cycle(4'b0010, 4'b0000, 1'b1, 1'b1);
    repeat (5) cycle(4'b0010, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b1, 1'b0);

    // watchdog: req2 granted then silent for MH cycles while req3 waits
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
    repeat (MH) cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    chk("t5_stall_err", 64'(bus.stall_err), 64'h1);
    chk("t5_grant",     64'(bus.grant),     64'h8);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b1);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b1);

    // wrap: pointer at 3, req3 then req0
    do_reset();
    cycle(4'b0100, 4'b0000, 1'b1, 1'b1);
    cycle(4'b1101, 4'b0100, 1'b1, 1'b1);
    cycle(4'b1001, 4'b1000, 1'b1, 1'b1);
    chk("t6_grant", 64'(bus.grant), 64'h1);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b1);

    // randomised phases with differing load, packet length and backpressure
    for (int ph = 0; ph < 3; ph++) begin
      repeat (400) cycle(rand_vec(pv[ph]), rand_vec(pl[ph]), ($urandom_range(99) < pr[ph]), 1'b1);
      do_reset();
    end

    cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
